uart_rx_frame: RTL



---
 rtl/uart_rx_frame.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: 16x ticks, 3-sample majority vote, false-start rejection,
// parity/frame/break detection and a valid/ready output stage that reports overrun.
module uart_rx_frame #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * 16);
  localparam int PW  = $clog2(DIV);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t                 state_reg, state_next;
  logic                   sync1_reg, rxs_reg;
  logic [PW-1:0]          presc_reg;
  logic [3:0]             samp_reg;
  logic [1:0]             vote_reg;
  logic [3:0]             bit_cnt_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   par_pend_reg;
  logic [DATA_BITS-1:0]   rx_data_reg;
  logic                   rx_valid_reg, parity_err_reg, frame_err_reg, overrun_reg;

  logic tick, mid, bit_end, maj, exp_par, start_go, stop_go;

  assign tick    = (presc_reg == PW'(DIV - 1));
  assign mid     = tick && (samp_reg == 4'd9);
  assign bit_end = tick && (samp_reg == 4'd15);
  // vote_reg holds samples 7 and 8; sample 9 is the live synchronized value
  assign maj     = (vote_reg[1] & vote_reg[0]) | (vote_reg[1] & rxs_reg) | (vote_reg[0] & rxs_reg);
  assign exp_par = (^shift_reg) ^ (PARITY_ODD != 0);

  always_comb begin
    state_next = state_reg;
    start_go   = 1'b0;
    stop_go    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (tick && !rxs_reg) begin
          state_next = S_START;
          start_go   = 1'b1;
        end
      end
      S_START: begin
        if (mid && maj)   state_next = S_IDLE;
        else if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_cnt_reg == 4'(DATA_BITS - 1)))
          state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_next = S_STOP;
      end
      S_STOP: begin
        // decide at mid-bit so the next start edge can be caught without delay
        if (mid) begin
          stop_go    = 1'b1;
          state_next = (!maj && (shift_reg == '0)) ? S_BREAK : S_IDLE;
        end
      end
      S_BREAK: begin
        if (tick && rxs_reg) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg      <= 1'b1;
      rxs_reg        <= 1'b1;
      presc_reg      <= '0;
      samp_reg       <= '0;
      vote_reg       <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      par_pend_reg   <= 1'b0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      sync1_reg <= rx_in;
      rxs_reg   <= sync1_reg;

      if (start_go || tick) presc_reg <= '0;
      else                  presc_reg <= presc_reg + PW'(1);

      if (start_go)  samp_reg <= '0;
      else if (tick) samp_reg <= samp_reg + 4'd1;

      if (tick && (samp_reg == 4'd7)) vote_reg[1] <= rxs_reg;
      if (tick && (samp_reg == 4'd8)) vote_reg[0] <= rxs_reg;

      if (start_go) begin
        bit_cnt_reg  <= '0;
        par_pend_reg <= 1'b0;
      end
      if ((state_reg == S_DATA) && mid)
        shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
      if ((state_reg == S_DATA) && bit_end)
        bit_cnt_reg <= bit_cnt_reg + 4'd1;
      if ((state_reg == S_PARITY) && mid && (maj != exp_par))
        par_pend_reg <= 1'b1;

      overrun_reg <= 1'b0;
      if (stop_go) begin
        if (!rx_valid_reg || rx_ready) begin
          rx_data_reg    <= shift_reg;
          parity_err_reg <= par_pend_reg;
          frame_err_reg  <= !maj;
          rx_valid_reg   <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign parity_err  = parity_err_reg;
  assign frame_err   = frame_err_reg;
  assign overrun_err = overrun_reg;
  assign rx_busy     = (state_reg != S_IDLE);

endmodule
